// File: rtl/bcd_countdown_timer.sv
// Loadable BCD MM:SS countdown timer with a 1 Hz prescaler and IDLE/RUN/DONE run control.
// BO pulses on the decrement that reaches 00:00; LdErr pulses when a load with non-BCD digits is rejected.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        CP,
    input  logic        CR,
    input  logic        LD,
    input  logic [15:0] D,
    input  logic        Start,
    input  logic        Stop,
    output logic [15:0] Q,
    output logic        Running,
    output logic        Done,
    output logic        BO,
    output logic        LdErr
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     q_reg, q_next;
    logic [PW-1:0]   pre_reg, pre_next;
    logic            bo_reg, bo_next;
    logic            lderr_reg, lderr_next;
    logic            d_legal;
    logic [15:0]     q_dec;

    // One-second BCD decrement; the M10 digit is never asked to underflow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m10, m1, s10, s1;
        logic       b;
        m10 = v[15:12];
        m1  = v[11:8];
        s10 = v[7:4];
        s1  = v[3:0];
        b   = (s1 == 4'd0);
        s1  = b ? 4'd9 : s1 - 4'd1;
        if (b) begin
            b   = (s10 == 4'd0);
            s10 = b ? 4'd5 : s10 - 4'd1;
        end
        if (b) begin
            b  = (m1 == 4'd0);
            m1 = b ? 4'd9 : m1 - 4'd1;
        end
        if (b) begin
            m10 = m10 - 4'd1;
        end
        return {m10, m1, s10, s1};
    endfunction

    assign d_legal = (D[15:12] <= 4'd9) && (D[11:8] <= 4'd9) &&
                     (D[7:4] <= 4'd5) && (D[3:0] <= 4'd9);
    assign q_dec   = bcd_dec(q_reg);

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_reg <= IDLE;
            q_reg     <= 16'h0000;
            pre_reg   <= '0;
            bo_reg    <= 1'b0;
            lderr_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            pre_reg   <= pre_next;
            bo_reg    <= bo_next;
            lderr_reg <= lderr_next;
        end
    end

    // Priority chain: LD > Stop > Start > prescaler tick.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        pre_next   = pre_reg;
        bo_next    = 1'b0;
        lderr_next = 1'b0;
        if (LD) begin
            if (d_legal) begin
                q_next     = D;
                state_next = IDLE;
                pre_next   = '0;
            end else begin
                lderr_next = 1'b1;
            end
        end else if (Stop && state_reg == RUN) begin
            state_next = IDLE;
        end else if (Start && state_reg == IDLE) begin
            if (q_reg != 16'h0000) begin
                state_next = RUN;
                pre_next   = '0;
            end else begin
                state_next = DONE;
            end
        end else if (state_reg == RUN) begin
            if (pre_reg == PRE_LAST) begin
                pre_next = '0;
                q_next   = q_dec;
                if (q_dec == 16'h0000) begin
                    state_next = DONE;
                    bo_next    = 1'b1;
                end
            end else begin
                pre_next = pre_reg + PW'(1);
            end
        end
    end

    assign Q       = q_reg;
    assign Running = (state_reg == RUN);
    assign Done    = (state_reg == DONE);
    assign BO      = bo_reg;
    assign LdErr   = lderr_reg;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: stimulus queues expected outputs tagged with the
// sampling cycle, and a negedge monitor pops and compares them.
module tb_bcd_countdown_timer;

    localparam int TICK_DIV = 4;

    logic        CP = 1'b0;
    logic        CR = 1'b1;
    logic        LD = 1'b0;
    logic [15:0] D = 16'h0000;
    logic        Start = 1'b0;
    logic        Stop = 1'b0;
    logic [15:0] Q;
    logic        Running;
    logic        Done;
    logic        BO;
    logic        LdErr;

    bcd_countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
        .CP(CP), .CR(CR), .LD(LD), .D(D), .Start(Start), .Stop(Stop),
        .Q(Q), .Running(Running), .Done(Done), .BO(BO), .LdErr(LdErr)
    );

    always #5 CP = ~CP;

    typedef struct {
        int          cyc;
        string       tag;
        logic [19:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [19:0] got;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic void expect_at(input int at, input string tag, input logic [15:0] q,
                                      input logic run, input logic done, input logic bo,
                                      input logic lderr);
        exp_t e;
        e.cyc = at;
        e.tag = tag;
        e.exp = {q, run, done, bo, lderr};
        sb.push_back(e);
    endfunction

    // Monitor: cycle n is the negedge following the n-th rising edge.
    always @(negedge CP) begin
        cyc = cyc + 1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            got = {Q, Running, Done, BO, LdErr};
            checks++;
            if (mon_e.cyc != cyc || got !== mon_e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d (due %0d): got Q=%h run=%b done=%b bo=%b lderr=%b, want Q=%h run=%b done=%b bo=%b lderr=%b",
                         mon_e.tag, cyc, mon_e.cyc, got[19:4], got[3], got[2], got[1], got[0],
                         mon_e.exp[19:4], mon_e.exp[3], mon_e.exp[2], mon_e.exp[1], mon_e.exp[0]);
            end else begin
                $display("check %s cycle %0d: Q=%h run=%b done=%b bo=%b lderr=%b ok",
                         mon_e.tag, cyc, got[19:4], got[3], got[2], got[1], got[0]);
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(negedge CP);
            #1;
            LD = 1'b0;
            Start = 1'b0;
            Stop = 1'b0;
        end
    endtask

    task automatic run_to(input int target);
        if (target > cyc) edges(target - cyc);
    endtask

    int c;
    int t;

    initial begin
        // Reset held for three cycles, then released.
        repeat (3) @(negedge CP);
        #1;
        CR = 1'b0;
        expect_at(cyc + 1, "reset_idle", 16'h0000, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        expect_at(cyc + 1, "start_at_zero", 16'h0000, 0, 1, 0, 0);
        run_to(cyc + 1);

        // Basic count from 01:00.
        LD = 1'b1; D = 16'h0100;
        expect_at(cyc + 1, "load_0100", 16'h0100, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        c = cyc + 1;
        expect_at(c,     "run_start",       16'h0100, 1, 0, 0, 0);
        expect_at(c + 3, "pre_before_tick", 16'h0100, 1, 0, 0, 0);
        expect_at(c + 4, "first_dec",       16'h0059, 1, 0, 0, 0);
        expect_at(c + 8, "second_dec",      16'h0058, 1, 0, 0, 0);
        run_to(c + 8);
        checks++;
        if (Q !== 16'h0058 || Running !== 1'b1) begin
            errors++;
            $display("FAIL direct_second_dec: Q=%h run=%b, want Q=0058 run=1", Q, Running);
        end else begin
            $display("check direct_second_dec: Q=%h run=%b ok", Q, Running);
        end

        // Terminal count.
        LD = 1'b1; D = 16'h0002;
        expect_at(cyc + 1, "load_0002", 16'h0002, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        c = cyc + 1;
        expect_at(c,      "run_0002",   16'h0002, 1, 0, 0, 0);
        expect_at(c + 4,  "dec_0001",   16'h0001, 1, 0, 0, 0);
        expect_at(c + 8,  "borrow_out", 16'h0000, 0, 1, 1, 0);
        expect_at(c + 9,  "bo_drops",   16'h0000, 0, 1, 0, 0);
        expect_at(c + 11, "done_holds", 16'h0000, 0, 1, 0, 0);
        run_to(c + 11);
        checks++;
        if (Q !== 16'h0000 || Done !== 1'b1 || BO !== 1'b0) begin
            errors++;
            $display("FAIL direct_done_hold: Q=%h done=%b bo=%b, want Q=0000 done=1 bo=0", Q, Done, BO);
        end else begin
            $display("check direct_done_hold: Q=%h done=%b bo=%b ok", Q, Done, BO);
        end

        // Borrow cascades.
        LD = 1'b1; D = 16'h1000;
        expect_at(cyc + 1, "load_1000", 16'h1000, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        c = cyc + 1;
        expect_at(c + 4, "cascade_0959", 16'h0959, 1, 0, 0, 0);
        run_to(c + 4);
        checks++;
        if (Q !== 16'h0959) begin
            errors++;
            $display("FAIL direct_cascade_0959: Q=%h, want Q=0959", Q);
        end else begin
            $display("check direct_cascade_0959: Q=%h ok", Q);
        end
        LD = 1'b1; D = 16'h9900;
        expect_at(cyc + 1, "load_9900", 16'h9900, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        c = cyc + 1;
        expect_at(c + 4, "cascade_9859", 16'h9859, 1, 0, 0, 0);
        run_to(c + 4);
        checks++;
        if (Q !== 16'h9859) begin
            errors++;
            $display("FAIL direct_cascade_9859: Q=%h, want Q=9859", Q);
        end else begin
            $display("check direct_cascade_9859: Q=%h ok", Q);
        end

        // Stop, then an illegal load is rejected.
        Stop = 1'b1;
        expect_at(cyc + 1, "stop_holds", 16'h9859, 0, 0, 0, 0);
        run_to(cyc + 1);
        LD = 1'b1; D = 16'h0070;
        c = cyc + 1;
        expect_at(c,     "illegal_load", 16'h9859, 0, 0, 0, 1);
        expect_at(c + 1, "lderr_drops",  16'h9859, 0, 0, 0, 0);
        run_to(c + 1);

        // Load arriving on a tick edge wins.
        LD = 1'b1; D = 16'h0100;
        expect_at(cyc + 1, "reload_0100", 16'h0100, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        c = cyc + 1;
        expect_at(c + 3, "before_tick", 16'h0100, 1, 0, 0, 0);
        run_to(c + 3);
        LD = 1'b1; D = 16'h0030;
        expect_at(c + 4, "load_beats_tick", 16'h0030, 0, 0, 0, 0);
        expect_at(c + 8, "idle_no_count",   16'h0030, 0, 0, 0, 0);
        run_to(c + 8);

        // Pause and resume: the partial second is discarded.
        LD = 1'b1; D = 16'h0100;
        expect_at(cyc + 1, "load_pause", 16'h0100, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        c = cyc + 1;
        expect_at(c + 2, "pre_two", 16'h0100, 1, 0, 0, 0);
        run_to(c + 2);
        Stop = 1'b1;
        expect_at(c + 3, "paused",      16'h0100, 0, 0, 0, 0);
        expect_at(c + 6, "paused_hold", 16'h0100, 0, 0, 0, 0);
        run_to(c + 6);
        Start = 1'b1;
        t = cyc + 1;
        expect_at(t,     "resume",            16'h0100, 1, 0, 0, 0);
        expect_at(t + 3, "no_partial_second", 16'h0100, 1, 0, 0, 0);
        expect_at(t + 4, "resume_dec",        16'h0059, 1, 0, 0, 0);
        run_to(t + 5);

        // Asynchronous clear mid-run, observed before the next rising edge.
        @(posedge CP);
        #2;
        CR = 1'b1;
        #1;
        checks++;
        if (Q !== 16'h0000 || Running !== 1'b0) begin
            errors++;
            $display("FAIL direct_async_clear: Q=%h run=%b, want Q=0000 run=0", Q, Running);
        end else begin
            $display("check direct_async_clear: Q=%h run=%b ok", Q, Running);
        end
        expect_at(cyc + 1, "async_clear", 16'h0000, 0, 0, 0, 0);
        @(negedge CP);
        #1;
        CR = 1'b0;
        expect_at(cyc + 1, "after_clear_idle", 16'h0000, 0, 0, 0, 0);
        run_to(cyc + 1);
        Start = 1'b1;
        expect_at(cyc + 1, "clear_then_start", 16'h0000, 0, 1, 0, 0);
        run_to(cyc + 1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CP);
        #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            errors++;
            $display("FAIL %s never sampled: due cycle %0d, now %0d", mon_e.tag, mon_e.cyc, cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
